// File: rtl/axi_dma_ctrl_2d_if.sv
// Control/handshake bundle between the engine top-level, the AXI master
// channels and the 2-D DMA control sequencer.
interface axi_dma_ctrl_2d_if #(
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned BIT_TRANS    = 18,
  parameter int unsigned BIT_BLK      = 16,
  parameter int unsigned BIT_ROW      = 11
);
  logic [1:0]              i_start;
  logic                    i_abort;
  logic [AXI_WIDTH_AD-1:0] i_base_address_rd;
  logic [AXI_WIDTH_AD-1:0] i_base_address_wr;
  logic [AXI_WIDTH_AD-1:0] i_row_stride_rd;
  logic [AXI_WIDTH_AD-1:0] i_row_stride_wr;
  logic [BIT_BLK-1:0]      i_rd_blks;
  logic [BIT_BLK-1:0]      i_wr_blks;
  logic [BIT_ROW-1:0]      i_num_rows;
  logic [BIT_TRANS-1:0]    i_num_trans;
  logic                    i_read_done;
  logic                    o_ctrl_read;
  logic [AXI_WIDTH_AD-1:0] o_read_addr;
  logic                    o_ctrl_read_done;
  logic                    i_write_done;
  logic                    i_indata_req_wr;
  logic                    o_ctrl_write;
  logic [AXI_WIDTH_AD-1:0] o_write_addr;
  logic [BIT_TRANS-1:0]    o_write_data_cnt;
  logic                    o_ctrl_write_done;
  logic                    o_busy_rd;
  logic                    o_busy_wr;
  logic [31:0]             o_rd_cycles;
  logic [31:0]             o_wr_cycles;

  // Engine/AXI side: drives commands and completions, observes requests.
  modport master (
    output i_start, i_abort, i_base_address_rd, i_base_address_wr, i_row_stride_rd,
           i_row_stride_wr, i_rd_blks, i_wr_blks, i_num_rows, i_num_trans, i_read_done,
           i_write_done, i_indata_req_wr,
    input  o_ctrl_read, o_read_addr, o_ctrl_read_done, o_ctrl_write, o_write_addr,
           o_write_data_cnt, o_ctrl_write_done, o_busy_rd, o_busy_wr, o_rd_cycles,
           o_wr_cycles
  );

  // Sequencer side.
  modport slave (
    input  i_start, i_abort, i_base_address_rd, i_base_address_wr, i_row_stride_rd,
           i_row_stride_wr, i_rd_blks, i_wr_blks, i_num_rows, i_num_trans, i_read_done,
           i_write_done, i_indata_req_wr,
    output o_ctrl_read, o_read_addr, o_ctrl_read_done, o_ctrl_write, o_write_addr,
           o_write_data_cnt, o_ctrl_write_done, o_busy_rd, o_busy_wr, o_rd_cycles,
           o_wr_cycles
  );
endinterface

// File: rtl/axi_dma_ctrl_2d.sv
// 2-D DMA control sequencer: walks rows x blocks for independent read and write
// channels, issuing one request per block and a region-done pulse at the end.
// Optional busy-cycle counters are built when DMA_CTRL_PERF_CNT_EN is defined.
module axi_dma_ctrl_2d #(
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned BIT_TRANS    = 18,
  parameter int unsigned BIT_BLK      = 16,
  parameter int unsigned BIT_ROW      = 11,
  parameter int unsigned BLK_LOG2     = 6
) (
  input logic              clk,
  input logic              rstn,
  axi_dma_ctrl_2d_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StDma, StWait, StSync, StDone, StZero} state_e;

  localparam logic [BIT_BLK-1:0]   BlkOne   = 1;
  localparam logic [BIT_ROW-1:0]   RowOne   = 1;
  localparam logic [BIT_TRANS-1:0] TransOne = 1;

  logic abort;
  assign abort = bus.i_abort;

  // ---------------------------------------------------------------- read channel
  state_e                  rd_state_q, rd_state_d;
  logic [AXI_WIDTH_AD-1:0] rd_base_q, rd_stride_q, rd_row_base_q;
  logic [BIT_BLK-1:0]      rd_blks_q, rd_blk_q;
  logic [BIT_ROW-1:0]      rd_rows_q, rd_row_q;
  logic                    rd_start, rd_accept, rd_blk_end, rd_last;

  assign rd_start   = (bus.i_start == 2'b10);
  assign rd_accept  = (rd_state_q == StIdle) && rd_start && !abort;
  assign rd_blk_end = (rd_blk_q == rd_blks_q - BlkOne);
  assign rd_last    = rd_blk_end && (rd_row_q == rd_rows_q - RowOne);

  // Read FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_state_q <= StIdle;
    else       rd_state_q <= rd_state_d;
  end

  // Read FSM next state; abort wins over start and done.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      StIdle: begin
        if (rd_start) begin
          rd_state_d = (bus.i_rd_blks == '0 || bus.i_num_rows == '0) ? StZero : StDma;
        end
      end
      StDma:  rd_state_d = StWait;
      StWait: if (bus.i_read_done) rd_state_d = rd_last ? StDone : StSync;
      StSync: rd_state_d = StDma;
      StDone: rd_state_d = StIdle;
      StZero: rd_state_d = StIdle;
      default: rd_state_d = StIdle;
    endcase
    if (abort) rd_state_d = StIdle;
  end

  // Read region parameters and block/row walk; row_base advances by stride.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_base_q     <= '0;
      rd_stride_q   <= '0;
      rd_row_base_q <= '0;
      rd_blks_q     <= '0;
      rd_rows_q     <= '0;
      rd_blk_q      <= '0;
      rd_row_q      <= '0;
    end else if (abort) begin
      rd_blk_q      <= '0;
      rd_row_q      <= '0;
      rd_row_base_q <= rd_base_q;
    end else if (rd_accept) begin
      rd_base_q     <= bus.i_base_address_rd;
      rd_stride_q   <= bus.i_row_stride_rd;
      rd_row_base_q <= bus.i_base_address_rd;
      rd_blks_q     <= bus.i_rd_blks;
      rd_rows_q     <= bus.i_num_rows;
      rd_blk_q      <= '0;
      rd_row_q      <= '0;
    end else if (rd_state_q == StWait && bus.i_read_done) begin
      if (rd_blk_end) begin
        rd_blk_q      <= '0;
        rd_row_q      <= rd_row_q + RowOne;
        rd_row_base_q <= rd_row_base_q + rd_stride_q;
      end else begin
        rd_blk_q <= rd_blk_q + BlkOne;
      end
    end else if (rd_state_q == StDone) begin
      rd_blk_q      <= '0;
      rd_row_q      <= '0;
      rd_row_base_q <= rd_base_q;
    end
  end

  assign bus.o_ctrl_read      = (rd_state_q == StDma);
  assign bus.o_ctrl_read_done = (rd_state_q == StDone) || (rd_state_q == StZero);
  assign bus.o_busy_rd        = (rd_state_q != StIdle);
  assign bus.o_read_addr      = rd_row_base_q + (AXI_WIDTH_AD'(rd_blk_q) << BLK_LOG2);

  // --------------------------------------------------------------- write channel
  state_e                  wr_state_q, wr_state_d;
  logic [AXI_WIDTH_AD-1:0] wr_base_q, wr_stride_q, wr_row_base_q;
  logic [BIT_BLK-1:0]      wr_blks_q, wr_blk_q;
  logic [BIT_ROW-1:0]      wr_rows_q, wr_row_q;
  logic [BIT_TRANS-1:0]    wr_trans_q, wr_cnt_q;
  logic                    wr_start, wr_accept, wr_blk_end, wr_last;

  assign wr_start   = (bus.i_start == 2'b11);
  assign wr_accept  = (wr_state_q == StIdle) && wr_start && !abort;
  assign wr_blk_end = (wr_blk_q == wr_blks_q - BlkOne);
  assign wr_last    = wr_blk_end && (wr_row_q == wr_rows_q - RowOne);

  // Write FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wr_state_q <= StIdle;
    else       wr_state_q <= wr_state_d;
  end

  // Write FSM next state; abort wins over start and done.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      StIdle: begin
        if (wr_start) begin
          wr_state_d = (bus.i_wr_blks == '0 || bus.i_num_rows == '0) ? StZero : StDma;
        end
      end
      StDma:  wr_state_d = StWait;
      StWait: if (bus.i_write_done) wr_state_d = wr_last ? StDone : StSync;
      StSync: wr_state_d = StDma;
      StDone: wr_state_d = StIdle;
      StZero: wr_state_d = StIdle;
      default: wr_state_d = StIdle;
    endcase
    if (abort) wr_state_d = StIdle;
  end

  // Write region parameters and block/row walk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_base_q     <= '0;
      wr_stride_q   <= '0;
      wr_row_base_q <= '0;
      wr_blks_q     <= '0;
      wr_rows_q     <= '0;
      wr_trans_q    <= '0;
      wr_blk_q      <= '0;
      wr_row_q      <= '0;
    end else if (abort) begin
      wr_blk_q      <= '0;
      wr_row_q      <= '0;
      wr_row_base_q <= wr_base_q;
    end else if (wr_accept) begin
      wr_base_q     <= bus.i_base_address_wr;
      wr_stride_q   <= bus.i_row_stride_wr;
      wr_row_base_q <= bus.i_base_address_wr;
      wr_blks_q     <= bus.i_wr_blks;
      wr_rows_q     <= bus.i_num_rows;
      wr_trans_q    <= bus.i_num_trans;
      wr_blk_q      <= '0;
      wr_row_q      <= '0;
    end else if (wr_state_q == StWait && bus.i_write_done) begin
      if (wr_blk_end) begin
        wr_blk_q      <= '0;
        wr_row_q      <= wr_row_q + RowOne;
        wr_row_base_q <= wr_row_base_q + wr_stride_q;
      end else begin
        wr_blk_q <= wr_blk_q + BlkOne;
      end
    end else if (wr_state_q == StDone) begin
      wr_blk_q      <= '0;
      wr_row_q      <= '0;
      wr_row_base_q <= wr_base_q;
    end
  end

  // Beat index within the current write block; restarts on each request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q <= '0;
    end else if (abort || wr_state_q == StDma) begin
      wr_cnt_q <= '0;
    end else if (bus.i_indata_req_wr) begin
      wr_cnt_q <= (wr_cnt_q == wr_trans_q - TransOne) ? '0 : wr_cnt_q + TransOne;
    end
  end

  assign bus.o_ctrl_write      = (wr_state_q == StDma);
  assign bus.o_ctrl_write_done = (wr_state_q == StDone) || (wr_state_q == StZero);
  assign bus.o_busy_wr         = (wr_state_q != StIdle);
  assign bus.o_write_data_cnt  = wr_cnt_q;
  assign bus.o_write_addr      = wr_row_base_q + (AXI_WIDTH_AD'(wr_blk_q) << BLK_LOG2)
                               + (AXI_WIDTH_AD'(wr_cnt_q) << 2);

  // ---------------------------------------------------------------- perf counters
`ifdef DMA_CTRL_PERF_CNT_EN
  logic [31:0] rd_cyc_q, wr_cyc_q;

  // Saturating busy-cycle counters, cleared on each accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cyc_q <= '0;
      wr_cyc_q <= '0;
    end else begin
      if (rd_accept)                                rd_cyc_q <= '0;
      else if (rd_state_q != StIdle && rd_cyc_q != '1) rd_cyc_q <= rd_cyc_q + 32'd1;
      if (wr_accept)                                wr_cyc_q <= '0;
      else if (wr_state_q != StIdle && wr_cyc_q != '1) wr_cyc_q <= wr_cyc_q + 32'd1;
    end
  end

  assign bus.o_rd_cycles = rd_cyc_q;
  assign bus.o_wr_cycles = wr_cyc_q;
`else
  assign bus.o_rd_cycles = '0;
  assign bus.o_wr_cycles = '0;
`endif

endmodule

// File: tb/tb_axi_dma_ctrl_2d.sv
// Directed bench for axi_dma_ctrl_2d: expected addresses are queued when a
// region is started and popped as request pulses / beats appear.
module tb_axi_dma_ctrl_2d;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   rd_req_cnt = 0, rd_done_cnt = 0, wr_done_cnt = 0;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] e;
  int   snap;

  always #5 clk = ~clk;

  axi_dma_ctrl_2d_if dif ();

  axi_dma_ctrl_2d dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dif.slave)
  );

  // Pulse counters sampled at the active edge (outputs from the previous cycle).
  always @(posedge clk) begin
    if (dif.o_ctrl_read)       rd_req_cnt  <= rd_req_cnt + 1;
    if (dif.o_ctrl_read_done)  rd_done_cnt <= rd_done_cnt + 1;
    if (dif.o_ctrl_write_done) wr_done_cnt <= wr_done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string tag, bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_req();
    int n = 0;
    while (!dif.o_ctrl_read && n < 30) begin step(); n++; end
    chk("rd_req_seen", dif.o_ctrl_read === 1'b1);
  endtask

  task automatic wait_wr_req();
    int n = 0;
    while (!dif.o_ctrl_write && n < 30) begin step(); n++; end
    chk("wr_req_seen", dif.o_ctrl_write === 1'b1);
  endtask

  task automatic pulse_rd_done();
    dif.i_read_done = 1'b1;
    step();
    dif.i_read_done = 1'b0;
  endtask

  initial begin
    dif.i_start = 2'b00;           dif.i_abort = 1'b0;
    dif.i_base_address_rd = '0;    dif.i_base_address_wr = '0;
    dif.i_row_stride_rd = '0;      dif.i_row_stride_wr = '0;
    dif.i_rd_blks = '0;            dif.i_wr_blks = '0;
    dif.i_num_rows = '0;           dif.i_num_trans = '0;
    dif.i_read_done = 1'b0;        dif.i_write_done = 1'b0;
    dif.i_indata_req_wr = 1'b0;
    step(); step();

    // Reset state
    chk("rst_ctrl_read", dif.o_ctrl_read === 1'b0);
    chk("rst_read_addr", dif.o_read_addr === 32'h0);
    chk("rst_write_addr", dif.o_write_addr === 32'h0);
    chk("rst_data_cnt", dif.o_write_data_cnt === 18'h0);
    chk("rst_busy_rd", dif.o_busy_rd === 1'b0);
    chk("rst_busy_wr", dif.o_busy_wr === 1'b0);
    chk("rst_rd_cycles", dif.o_rd_cycles === 32'h0);
    rstn = 1'b1;
    step();

    // Stray read done in IDLE is ignored
    pulse_rd_done();
    chk("stray_done_busy", dif.o_busy_rd === 1'b0);
    chk("stray_done_pulse", dif.o_ctrl_read_done === 1'b0);

    // Read region: 2 rows x 3 blocks
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 3; b++) rd_q.push_back(32'h1000 + r * 32'h400 + b * 32'h40);
    dif.i_base_address_rd = 32'h1000; dif.i_row_stride_rd = 32'h400;
    dif.i_rd_blks = 16'd3;            dif.i_num_rows = 11'd2;
    dif.i_start = 2'b10;
    step();
    dif.i_start = 2'b00;
    for (int k = 0; k < 6; k++) begin
      wait_rd_req();
      e = rd_q.pop_front();
      chk("rd_addr", dif.o_read_addr === e);
      step();
      chk("rd_req_one_cycle", dif.o_ctrl_read === 1'b0);
      if (k == 0) begin
        // Start while busy, with a different base, must be ignored
        dif.i_base_address_rd = 32'hF000;
        dif.i_start = 2'b10;
        step();
        dif.i_start = 2'b00;
        dif.i_base_address_rd = 32'h1000;
      end else begin
        step();
      end
      step(); step();
      pulse_rd_done();
      if (k < 5) chk("rd_done_early", dif.o_ctrl_read_done === 1'b0);
      else       chk("rd_done_pulse", dif.o_ctrl_read_done === 1'b1);
    end
    chk("rd_busy_in_done", dif.o_busy_rd === 1'b1);
    step();
    chk("rd_busy_after", dif.o_busy_rd === 1'b0);
    chk("rd_done_width", dif.o_ctrl_read_done === 1'b0);
    step();
    chk("rd_done_count", rd_done_cnt === 1);
    chk("rd_req_count", rd_req_cnt === 6);

    // Write region: 1 row x 2 blocks x 16 beats
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < 16; t++) wr_q.push_back(32'h8000 + b * 32'h40 + t * 4);
    dif.i_base_address_wr = 32'h8000; dif.i_row_stride_wr = 32'h1000;
    dif.i_wr_blks = 16'd2;            dif.i_num_rows = 11'd1;
    dif.i_num_trans = 18'd16;
    dif.i_start = 2'b11;
    step();
    dif.i_start = 2'b00;
    for (int b = 0; b < 2; b++) begin
      wait_wr_req();
      step();
      for (int t = 0; t < 16; t++) begin
        e = wr_q.pop_front();
        chk("wr_addr", dif.o_write_addr === e);
        chk("wr_data_cnt", dif.o_write_data_cnt === 18'(t));
        dif.i_indata_req_wr = 1'b1;
        step();
        dif.i_indata_req_wr = 1'b0;
      end
      chk("wr_cnt_wrap", dif.o_write_data_cnt === 18'h0);
      dif.i_write_done = 1'b1;
      step();
      dif.i_write_done = 1'b0;
      chk("wr_done_pulse", dif.o_ctrl_write_done === ((b == 1) ? 1'b1 : 1'b0));
    end
    step(); step();
    chk("wr_busy_after", dif.o_busy_wr === 1'b0);
    chk("wr_done_count", wr_done_cnt === 1);

    // Zero-size read (rows=0): done pulse next cycle, no request
    dif.i_rd_blks = 16'd3; dif.i_num_rows = 11'd0;
    dif.i_start = 2'b10;
    step();
    dif.i_start = 2'b00;
    chk("zero_rd_done", dif.o_ctrl_read_done === 1'b1);
    chk("zero_rd_noreq", dif.o_ctrl_read === 1'b0);
    step();
    chk("zero_rd_idle", dif.o_busy_rd === 1'b0);
    chk("zero_rd_reqcnt", rd_req_cnt === 6);

    // Zero-size write (blks=0)
    dif.i_wr_blks = 16'd0; dif.i_num_rows = 11'd1;
    dif.i_start = 2'b11;
    step();
    dif.i_start = 2'b00;
    chk("zero_wr_done", dif.o_ctrl_write_done === 1'b1);
    chk("zero_wr_noreq", dif.o_ctrl_write === 1'b0);
    step();
    chk("zero_wr_idle", dif.o_busy_wr === 1'b0);
`ifdef DMA_CTRL_PERF_CNT_EN
    chk("zero_wr_cycles", dif.o_wr_cycles === 32'd1);
`else
    chk("zero_wr_cycles", dif.o_wr_cycles === 32'd0);
`endif

    // Abort during WAIT of block 2, then restart from the base
    for (int b = 0; b < 3; b++) rd_q.push_back(32'h2000 + b * 32'h40);
    rd_q.push_back(32'h2000);
    dif.i_base_address_rd = 32'h2000; dif.i_row_stride_rd = 32'h100;
    dif.i_rd_blks = 16'd4;            dif.i_num_rows = 11'd1;
    dif.i_start = 2'b10;
    step();
    dif.i_start = 2'b00;
    for (int k = 0; k < 3; k++) begin
      wait_rd_req();
      e = rd_q.pop_front();
      chk("abort_rd_addr", dif.o_read_addr === e);
      step(); step();
      if (k < 2) pulse_rd_done();
    end
    snap = rd_done_cnt;
    dif.i_abort = 1'b1;
    step();
    dif.i_abort = 1'b0;
    chk("abort_idle", dif.o_busy_rd === 1'b0);
    chk("abort_no_done", dif.o_ctrl_read_done === 1'b0);
    chk("abort_addr_base", dif.o_read_addr === 32'h2000);
    step(); step();
    chk("abort_done_count", rd_done_cnt === snap);
    dif.i_start = 2'b10;
    step();
    dif.i_start = 2'b00;
    chk("restart_req", dif.o_ctrl_read === 1'b1);
    e = rd_q.pop_front();
    chk("restart_addr", dif.o_read_addr === e);
    dif.i_abort = 1'b1;
    step();
    dif.i_abort = 1'b0;
    step();

    // Single-block read spanning 10 busy cycles: DMA + 8 WAIT + DONE
    dif.i_base_address_rd = 32'h3000; dif.i_rd_blks = 16'd1; dif.i_num_rows = 11'd1;
    dif.i_start = 2'b10;
    step();
    dif.i_start = 2'b00;
    chk("perf_req", dif.o_ctrl_read === 1'b1);
    for (int i = 0; i < 8; i++) step();
    pulse_rd_done();
    chk("perf_done", dif.o_ctrl_read_done === 1'b1);
    step(); step(); step();
`ifdef DMA_CTRL_PERF_CNT_EN
    chk("perf_rd_cycles", dif.o_rd_cycles === 32'd10);
`else
    chk("perf_rd_cycles", dif.o_rd_cycles === 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_dma_ctrl_2d.md
# axi_dma_ctrl_2d

Parametrised 2-D DMA control sequencer that sits between the engine's top-level control and the AXI master read/write channels. It issues per-block read and write requests over a rectangular region of rows × blocks with independent row strides. It adds abort, zero-size handling and optional performance counters. It contains control logic only and has no AXI interface.

## Interface
- AXI_WIDTH_AD, 32: address width
- BIT_TRANS, 18: width of beat counter / num_trans
- BIT_BLK, 16: width of blocks-per-row counters
- BIT_ROW, 11: width of row counters
- BLK_LOG2, 6: log2 of block size in bytes (64 B)
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_start  in  2  2'b10 start read, 2'b11 start write, else no-op
- i_abort  in  1  level; aborts both channels
- i_base_address_rd / i_base_address_wr  in  AXI_WIDTH_AD  region base byte addresses
- i_row_stride_rd / i_row_stride_wr  in  AXI_WIDTH_AD  byte distance between rows
- i_rd_blks / i_wr_blks  in  BIT_BLK  blocks per row
- i_num_rows  in  BIT_ROW  rows (shared by both channels)
- i_num_trans  in  BIT_TRANS  beats per write block
- i_read_done  in  1  read block complete pulse
- o_ctrl_read  out  1  read request pulse
- o_read_addr  out  AXI_WIDTH_AD  current read block address
- o_ctrl_read_done  out  1  read region complete pulse
- i_write_done  in  1  write block complete pulse
- i_indata_req_wr  in  1  write beat accepted
- o_ctrl_write  out  1  write request pulse
- o_write_addr  out  AXI_WIDTH_AD  current write beat address
- o_write_data_cnt  out  BIT_TRANS  beat index in block
- o_ctrl_write_done  out  1  write region complete pulse
- o_busy_rd / o_busy_wr  out  1  channel FSM not IDLE
- o_rd_cycles / o_wr_cycles  out  32  busy-cycle counters (see Configuration)

## Operation
- Two independent FSMs (read, write), states IDLE, DMA, WAIT, SYNC, DONE, ZERO.
- IDLE: on matching i_start, latch base, stride, blks, rows (and num_trans for write); go to ZERO if blks==0 or rows==0, else DMA. i_start for a busy channel is ignored.
- DMA: assert request pulse for one cycle -> WAIT.
- WAIT: on done, if blk==blks-1 and row==rows-1 go to DONE, else go to SYNC. Done pulses outside WAIT are ignored.
- SYNC: go to DMA. DONE: assert done pulse for one cycle, clear counters, go to IDLE. ZERO: assert done pulse for one cycle, go to IDLE, issue no requests.
- On an accepted done, blk increments. At blk==blks-1, blk clears, row increments and row_base += stride. There is no multiplier.
- o_read_addr = row_base_rd + (blk_rd << BLK_LOG2).
- o_write_addr = row_base_wr + (blk_wr << BLK_LOG2) + (o_write_data_cnt << 2).
- All address arithmetic is modulo 2^AXI_WIDTH_AD.
- o_write_data_cnt: cleared on o_ctrl_write. It increments on i_indata_req_wr and wraps to 0 after i_num_trans-1.
- i_abort high: both FSMs go to IDLE on the next edge. All counters and row_base are reset to the latched base, and no done pulse is issued. Abort overrides simultaneous start and done.

## Timing
- Reset values: all outputs 0. FSMs are in IDLE, counters 0, addresses 0 until the first start latches a base.
- Start sampled at edge t: request pulse in cycle t+1, address valid from t+1.
- Done at edge t in WAIT: counters update at t. Next request pulse at t+2 (SYNC, DMA); the address is stable for both cycles.
- Last done at edge t: region-done pulse in cycle t+1, busy deasserts at t+2.
- Zero-size start at edge t: done pulse in cycle t+1, with no request.
- Read and write may run concurrently; their state is fully independent.

## Configuration
- DMA_CTRL_PERF_CNT_EN defined: o_rd_cycles / o_wr_cycles count clk cycles with the channel busy. They clear on that channel's accepted start and hold after done. They saturate at 0xFFFFFFFF.
- DMA_CTRL_PERF_CNT_EN not defined: the counters are not built, and o_rd_cycles and o_wr_cycles are constant 0.

## Test plan
- Read, base 0x1000, stride 0x400, rd_blks=3, rows=2, done 5 cycles after each request -> addresses 0x1000, 0x1040, 0x1080, 0x1400, 0x1440, 0x1480. Exactly one o_ctrl_read_done, 1 cycle after the 6th done.
- Write, base 0x8000, wr_blks=2, rows=1, num_trans=16, 16 beats per block -> o_write_addr runs 0x8000..0x803C, then 0x8040..0x807C. o_write_data_cnt wraps 15->0, then o_ctrl_write_done.
- rows=0 or blks=0 -> no request pulse, and the done pulse arrives 1 cycle after start.
- Abort during WAIT of block 2 -> IDLE next cycle with no done pulse. A restart issues the base address again.
- Start while busy, and stray read_done in IDLE -> both ignored, and the sequence is unchanged.
- PERF_EN: read 1 block taking 10 busy cycles -> o_rd_cycles=10. Without the macro -> 0.
